// File: rtl/dcs_switch_ctrl_if.sv
// Request handshake bundle for the DCS switch controller.
// Signals:
//   req_valid - requester has a switch request pending
//   req_sel   - DCS input the requester wants selected
//   req_ready - controller can take a request this cycle
// The master modport belongs to the requester; the slave modport belongs to the controller.
interface dcs_switch_ctrl_if;
   logic req_valid;
   logic req_sel;
   logic req_ready;

   modport master (output req_valid, output req_sel, input req_ready);
   modport slave  (input req_valid, input req_sel, output req_ready);
endinterface

// File: rtl/dcs_switch_ctrl.sv
// Sequencer for a single LIFCL DCS (dynamic clock select) primitive.
//
// A switch request arrives on the req handshake. The controller then moves dcs_sel to
// the target input and waits for the target clock to show activity. If the target stays
// dead for TIMEOUT_CYCLES cycles, the controller forces the switch with dcs_selforce.
// After that it holds a settle window, reports the switch done, and blocks new requests
// for a minimum dwell time.
//
// Ports:
//   clk           - controller clock; free-running and independent of both DCS inputs
//   rst           - asynchronous, active-high reset
//   req           - request handshake (req_valid / req_sel in, req_ready out)
//   clk_alive     - per-input activity flags, already synchronised to clk
//   dcs_sel       - drives DCS SEL
//   dcs_selforce  - drives DCS SELFORCE (1 = non-glitchless forced switch)
//   cur_sel       - input currently reported as active
//   busy          - controller is not idle
//   done_pulse    - one-cycle pulse when a request completes
//   timeout_pulse - one-cycle pulse when the target never came alive and the switch was forced
module dcs_switch_ctrl #(
   parameter logic        INIT_SEL       = 1'b0,
   parameter int unsigned SETTLE_CYCLES  = 8,
   parameter int unsigned DWELL_CYCLES   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   dcs_switch_ctrl_if.slave         req,
   input  logic [1:0]               clk_alive,
   output logic                     dcs_sel,
   output logic                     dcs_selforce,
   output logic                     cur_sel,
   output logic                     busy,
   output logic                     done_pulse,
   output logic                     timeout_pulse
);

   typedef enum logic [1:0] {
      IDLE,
      SWITCH,
      SETTLE,
      DWELL
   } state_t;

   localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] DWELL_LAST   = 16'(DWELL_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        tgt_q, tgt_d;
   logic        dcs_sel_q, dcs_sel_d;
   logic        selforce_q, selforce_d;
   logic        cur_sel_q, cur_sel_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        timeout_q, timeout_d;

   // State and output registers. Every output comes from a flop, so the DCS pins see no
   // combinational glitches. Reset restores the initial selection and drops any switch
   // that is in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tgt_q      <= INIT_SEL;
         dcs_sel_q  <= INIT_SEL;
         selforce_q <= 1'b0;
         cur_sel_q  <= INIT_SEL;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tgt_q      <= tgt_d;
         dcs_sel_q  <= dcs_sel_d;
         selforce_q <= selforce_d;
         cur_sel_q  <= cur_sel_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next-state and next-output logic. The counter returns to zero on every state change,
   // so each phase counts from a clean start. A request whose target is already the active
   // input completes at once and stays in IDLE. req_ready and busy are computed from the
   // next state, so they line up with the state register.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tgt_d      = tgt_q;
      dcs_sel_d  = dcs_sel_q;
      selforce_d = selforce_q;
      cur_sel_d  = cur_sel_q;
      done_d     = 1'b0;
      timeout_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (req.req_valid && ready_q) begin
               if (req.req_sel == cur_sel_q) begin
                  done_d = 1'b1;
               end else begin
                  tgt_d     = req.req_sel;
                  dcs_sel_d = req.req_sel;
                  state_d   = SWITCH;
                  cnt_d     = '0;
               end
            end
         end
         SWITCH: begin
            if (clk_alive[tgt_q]) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               selforce_d = 1'b1;
               timeout_d  = 1'b1;
               state_d    = SETTLE;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cur_sel_d  = tgt_q;
               done_d     = 1'b1;
               selforce_d = 1'b0;
               state_d    = DWELL;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DWELL: begin
            if (cnt_q == DWELL_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   assign req.req_ready   = ready_q;
   assign dcs_sel         = dcs_sel_q;
   assign dcs_selforce    = selforce_q;
   assign cur_sel         = cur_sel_q;
   assign busy            = busy_q;
   assign done_pulse      = done_q;
   assign timeout_pulse   = timeout_q;

endmodule
